// File: rtl/lanes_dist_param.sv
// lanes_dist_param: spreads NUM_CW interleaved RS codewords (SYM_W-bit symbols) round-robin
// across NUM_LANES physical lanes, MSB symbol first, and raises a per-lane AM sync flag every
// AM_PERIOD accepted codeword sets. A runtime half-lane mode uses only the lower NUM_LANES/2
// lanes and emits each set as two consecutive output beats.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   i_valid      input set valid
//   o_ready      a set is accepted this cycle when i_valid is also high
//   i_half_mode  1 = half-lane mode for the set being accepted
//   i_words      codeword c at [c*CW_W +: CW_W], symbol s at [s*SYM_W +: SYM_W]
//   o_valid      output beat valid (one cycle after accept)
//   o_lanes      lane l at [l*LANE_W +: LANE_W], slot k / codeword c at [(NUM_CW*k+c)*SYM_W]
//   o_sync       per-lane AM sync flag, qualified by o_valid
//
// Optional feature (macro LANES_DIST_STATS_EN): adds o_set_cnt (accepted sets) and o_am_cnt
// (sync flags raised), both 32-bit wrapping counters cleared by reset.
module lanes_dist_param #(
  parameter int unsigned SYM_W     = 10,
  parameter int unsigned NUM_CW    = 4,
  parameter int unsigned CW_SYMS   = 544,
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned AM_PERIOD = 8192
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    i_valid,
  output logic                                                    o_ready,
  input  logic                                                    i_half_mode,
  input  logic [NUM_CW*CW_SYMS*SYM_W-1:0]                         i_words,
  output logic                                                    o_valid,
  output logic [NUM_LANES*(CW_SYMS/NUM_LANES)*NUM_CW*SYM_W-1:0]   o_lanes,
  output logic [NUM_LANES-1:0]                                    o_sync
`ifdef LANES_DIST_STATS_EN
  ,
  output logic [31:0]                                             o_set_cnt,
  output logic [31:0]                                             o_am_cnt
`endif
);

  localparam int unsigned CW_W   = CW_SYMS * SYM_W;
  localparam int unsigned S      = CW_SYMS / NUM_LANES;
  localparam int unsigned LANE_W = S * NUM_CW * SYM_W;
  localparam int unsigned H      = NUM_LANES / 2;
  localparam int unsigned TOT_W  = NUM_LANES * LANE_W;
  localparam int unsigned CNT_W  = (AM_PERIOD > 2) ? $clog2(AM_PERIOD) : 1;

  localparam logic [NUM_LANES-1:0] FULL_SYNC = {NUM_LANES{1'b1}};
  localparam logic [NUM_LANES-1:0] HALF_SYNC = {{(NUM_LANES - H){1'b0}}, {H{1'b1}}};

  if ((NUM_LANES % 2) != 0 || (CW_SYMS % NUM_LANES) != 0 || AM_PERIOD < 2) begin : g_cfg_err
    $error("lanes_dist_param: NUM_LANES must be even, divide CW_SYMS, and AM_PERIOD >= 2");
  end

  typedef enum logic [0:0] {StAccept, StSecond} state_e;

  state_e               state_q, state_d;
  logic                 accept;
  logic                 sync_hit;
  logic [TOT_W-1:0]     full_map, half_b0, half_b1;
  logic [TOT_W-1:0]     lanes_q, beat1_q;
  logic                 valid_q;
  logic [NUM_LANES-1:0] sync_q;
  logic [CNT_W-1:0]     am_cnt_q;
  logic                 prev_half_q;

  assign o_ready = (state_q == StAccept);
  assign accept  = o_ready && i_valid;
  // A mode change restarts the AM period so the receiver realigns on the new lane count.
  assign sync_hit = (am_cnt_q == CNT_W'(AM_PERIOD - 1)) || (i_half_mode != prev_half_q);

  // Transmit position n maps to symbol index CW_SYMS-1-n. Full mode: n = NUM_LANES*k + l.
  // Half mode: n = H*(b*S + k) + l for beat b, lanes H.. stay zero.
  always_comb begin
    full_map = '0;
    half_b0  = '0;
    half_b1  = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      for (int unsigned k = 0; k < S; k++) begin
        for (int unsigned c = 0; c < NUM_CW; c++) begin
          full_map[l*LANE_W + (NUM_CW*k + c)*SYM_W +: SYM_W] =
            i_words[c*CW_W + (CW_SYMS - 1 - (NUM_LANES*k + l))*SYM_W +: SYM_W];
          if (l < H) begin
            half_b0[l*LANE_W + (NUM_CW*k + c)*SYM_W +: SYM_W] =
              i_words[c*CW_W + (CW_SYMS - 1 - (H*k + l))*SYM_W +: SYM_W];
            half_b1[l*LANE_W + (NUM_CW*k + c)*SYM_W +: SYM_W] =
              i_words[c*CW_W + (CW_SYMS - 1 - (H*(S + k) + l))*SYM_W +: SYM_W];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccept: if (accept && i_half_mode) state_d = StSecond;
      StSecond: state_d = StAccept;
      default:  state_d = StAccept;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAccept;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      lanes_q     <= '0;
      beat1_q     <= '0;
      sync_q      <= '0;
      am_cnt_q    <= CNT_W'(AM_PERIOD - 1);
      prev_half_q <= 1'b0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      lanes_q     <= i_half_mode ? half_b0 : full_map;
      if (i_half_mode) beat1_q <= half_b1;
      sync_q      <= sync_hit ? (i_half_mode ? HALF_SYNC : FULL_SYNC) : '0;
      am_cnt_q    <= sync_hit ? '0 : am_cnt_q + CNT_W'(1);
      prev_half_q <= i_half_mode;
    end else if (state_q == StSecond) begin
      valid_q <= 1'b1;
      lanes_q <= beat1_q;
      sync_q  <= '0;
    end else begin
      // Idle: lanes hold their last value.
      valid_q <= 1'b0;
      sync_q  <= '0;
    end
  end

  assign o_valid = valid_q;
  assign o_lanes = lanes_q;
  assign o_sync  = sync_q;

`ifdef LANES_DIST_STATS_EN
  logic [31:0] set_cnt_q, am_flag_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      set_cnt_q     <= '0;
      am_flag_cnt_q <= '0;
    end else if (accept) begin
      set_cnt_q <= set_cnt_q + 32'd1;
      if (sync_hit) am_flag_cnt_q <= am_flag_cnt_q + 32'd1;
    end
  end

  assign o_set_cnt = set_cnt_q;
  assign o_am_cnt  = am_flag_cnt_q;
`endif

endmodule

// File: tb/tb_lanes_dist_param.sv
// Bench for lanes_dist_param: a driver issues randomized sets, a transaction-level reference
// model pushes the expected beats (with their expected cycle) into a queue, and a monitor
// pops and compares whenever o_valid is seen.
module tb_lanes_dist_param;

  localparam int SYM_W     = 10;
  localparam int NUM_CW    = 4;
  localparam int CW_SYMS   = 544;
  localparam int NL        = 16;
  localparam int AM_PERIOD = 8192;
  localparam int CW_W      = CW_SYMS * SYM_W;
  localparam int S         = CW_SYMS / NL;
  localparam int LANE_W    = S * NUM_CW * SYM_W;
  localparam int H         = NL / 2;
  localparam int IN_W      = NUM_CW * CW_W;
  localparam int TOT_W     = NL * LANE_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic              i_half_mode = 1'b0;
  logic [IN_W-1:0]   i_words = '0;
  logic              o_valid;
  logic [TOT_W-1:0]  o_lanes;
  logic [NL-1:0]     o_sync;
`ifdef LANES_DIST_STATS_EN
  logic [31:0]       o_set_cnt, o_am_cnt;
`endif

  always #5 clk = ~clk;

  lanes_dist_param dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_half_mode (i_half_mode),
    .i_words     (i_words),
    .o_valid     (o_valid),
    .o_lanes     (o_lanes),
    .o_sync      (o_sync)
`ifdef LANES_DIST_STATS_EN
    ,
    .o_set_cnt   (o_set_cnt),
    .o_am_cnt    (o_am_cnt)
`endif
  );

  typedef struct {
    logic [TOT_W-1:0] lanes;
    logic [NL-1:0]    sync;
    int               cyc;
  } beat_t;

  beat_t exp_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  // Reference-model state.
  int               m_cnt;
  bit               m_prev_half;
  bit               m_second;
  bit               pend;
  logic [TOT_W-1:0] pend_lanes;
  int               m_sets;
  int               m_syncs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_lanes(input string name, input logic [TOT_W-1:0] act,
                             input logic [TOT_W-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      for (int i = 0; i < TOT_W / SYM_W; i++) begin
        if (act[i*SYM_W +: SYM_W] !== exp[i*SYM_W +: SYM_W]) begin
          $display("FAIL %s: lane %0d sym %0d got %0d want %0d (cycle %0d)", name,
                   i / (LANE_W / SYM_W), i % (LANE_W / SYM_W), act[i*SYM_W +: SYM_W],
                   exp[i*SYM_W +: SYM_W], cyc);
          break;
        end
      end
    end
  endtask

  // Walk each codeword in transmit order and deal symbols out to lanes like cards.
  function automatic logic [TOT_W-1:0] model_map(input logic [IN_W-1:0] w, input bit half,
                                                 input int beat);
    logic [TOT_W-1:0] r;
    int used;
    r = '0;
    used = half ? H : NL;
    for (int c = 0; c < NUM_CW; c++) begin
      for (int n = 0; n < CW_SYMS; n++) begin
        int l, t, b, k;
        l = n % used;
        t = n / used;
        b = t / S;
        k = t % S;
        if (b == beat)
          r[l*LANE_W + (NUM_CW*k + c)*SYM_W +: SYM_W] = w[c*CW_W + (CW_SYMS-1-n)*SYM_W +: SYM_W];
      end
    end
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_words();
    logic [IN_W-1:0] r;
    for (int i = 0; i < IN_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [IN_W-1:0] index_words();
    logic [IN_W-1:0] r;
    for (int c = 0; c < NUM_CW; c++)
      for (int s = 0; s < CW_SYMS; s++) r[c*CW_W + s*SYM_W +: SYM_W] = SYM_W'(s);
    return r;
  endfunction

  task automatic model_reset();
    m_cnt       = AM_PERIOD - 1;
    m_prev_half = 1'b0;
    m_second    = 1'b0;
    pend        = 1'b0;
    m_sets      = 0;
    m_syncs     = 0;
  endtask

  // Entered and left at a negedge.
  task automatic step(input bit v, input bit half, input logic [IN_W-1:0] w);
    beat_t e;
    bit    sync_now;
    check_eq("ready", o_ready, !m_second);
    if (pend) begin
      e.lanes = pend_lanes;
      e.sync  = '0;
      e.cyc   = cyc + 1;
      exp_q.push_back(e);
      pend = 1'b0;
    end
    i_valid     = v;
    i_half_mode = half;
    i_words     = w;
    if (v && !m_second) begin
      sync_now = (m_cnt == AM_PERIOD - 1) || (half != m_prev_half);
      m_cnt    = sync_now ? 0 : m_cnt + 1;
      m_prev_half = half;
      m_sets++;
      if (sync_now) m_syncs++;
      e.lanes = model_map(w, half, 0);
      e.sync  = sync_now ? (half ? NL'((1 << H) - 1) : {NL{1'b1}}) : '0;
      e.cyc   = cyc + 1;
      exp_q.push_back(e);
      if (half) begin
        pend       = 1'b1;
        pend_lanes = model_map(w, 1'b1, 1);
      end
      m_second = half;
    end else begin
      m_second = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_eq("reset o_valid", o_valid, 0);
    check_eq("reset o_sync", o_sync, 0);
    check_eq("reset o_ready", o_ready, 1);
    check_lanes("reset o_lanes", o_lanes, '0);
  endtask

  // Monitor: compare every presented beat against the queue head.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check_eq("missing beat", 0, 1);
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected beat", 1, 0);
        end else if (exp_q[0].cyc != cyc) begin
          check_eq("early beat cycle", cyc, exp_q[0].cyc);
        end else begin
          e = exp_q.pop_front();
          check_lanes("beat lanes", o_lanes, e.lanes);
          check_eq("beat sync", o_sync, e.sync);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // Full-mode set, symbol value = index.
    step(1, 0, index_words());
    check_eq("full o_valid", o_valid, 1);
    check_eq("full o_sync", o_sync, 16'hFFFF);
    check_eq("full lane0 slot0 cw0", o_lanes[0 +: SYM_W], 543);
    check_eq("full lane1 slot1 cw1", o_lanes[LANE_W + 50 +: SYM_W], 526);

    // Half-mode set (mode change forces sync).
    step(1, 1, index_words());
    check_eq("half b0 lane0 slot0", o_lanes[0 +: SYM_W], 543);
    check_eq("half b0 lane0 slot1", o_lanes[40 +: SYM_W], 535);
    check_eq("half b0 upper lanes zero", o_lanes[TOT_W-1 -: H*LANE_W] == '0, 1);
    check_eq("half b0 o_sync", o_sync, 16'h00FF);
    check_eq("half o_ready during second", o_ready, 0);
    step(1, 0, rand_words());  // ignored: block is in its second-beat cycle
    check_eq("half b1 o_valid", o_valid, 1);
    check_eq("half b1 lane0 slot0", o_lanes[0 +: SYM_W], 271);
    check_eq("half b1 o_sync", o_sync, 0);
    step(0, 0, '0);

    // Reset while the second beat is pending.
    step(1, 1, rand_words());
    do_reset();
    step(0, 0, '0);
    check_eq("post-abort o_valid", o_valid, 0);
    step(1, 0, rand_words());
    check_eq("post-abort sync", o_sync, 16'hFFFF);

    // Ten sets with gaps, then the optional statistics.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 0, rand_words());
      if ($urandom_range(0, 1) == 1) step(0, $urandom_range(0, 1), rand_words());
    end
    repeat (3) step(0, 0, '0);
`ifdef LANES_DIST_STATS_EN
    check_eq("stats set_cnt", o_set_cnt, 10);
    check_eq("stats am_cnt", o_am_cnt, 1);
`endif

    // Continuous full mode: syncs on sets 1 and 8193.
    do_reset();
    for (int i = 0; i < AM_PERIOD + 1; i++) step(1, 0, rand_words());
    step(0, 0, '0);

    // Full -> half switch at set 100, then half mode through the next period.
    do_reset();
    for (int i = 0; i < 99; i++) step(1, 0, rand_words());
    for (int i = 0; i < 2 * (AM_PERIOD + 1); i++)
      step(1, m_second ? 1'($urandom_range(0, 1)) : 1'b1, rand_words());
    step(0, 0, '0);

    // Random mix of modes, gaps and aborted second beats.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_second && $urandom_range(0, 29) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rand_words());
    end

    for (int i = 0; i < 10 && (exp_q.size() > 0 || pend); i++) step(0, 0, '0);
    repeat (2) step(0, 0, '0);
    check_eq("scoreboard drained", exp_q.size(), 0);
`ifdef LANES_DIST_STATS_EN
    check_eq("stats set_cnt model", o_set_cnt, m_sets);
    check_eq("stats am_cnt model", o_am_cnt, m_syncs);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
